// File: rtl/ram_loader_pkg.sv
// ram_loader_pkg: shared types for the boot RAM loader.
//   state_t        - loader FSM states (CHECK only reachable with
//                    RAM_LOADER_CHECKSUM_EN defined)
//   bytes_per_word - bytes packed into one RAM word of a given width
package ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    SETUP,
    STROBE,
    HOLD,
    CHECK,
    DONE
  } state_t;

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/ram_loader_if.sv
// ram_loader_if: byte-stream input and RAM write bus of the loader.
//   rx_data/rx_valid/rx_ready   - valid/ready byte stream from the receiver
//   ram_address/ram_data/ram_load - RAM write port; RAM captures on the
//                                   rising edge of ram_load
// master: the loader. slave: the receiver/RAM side.
interface ram_loader_if #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] ram_address;
  logic [DATA_WIDTH-1:0] ram_data;
  logic                  ram_load;

  modport master (input rx_data, rx_valid,
                  output rx_ready, ram_address, ram_data, ram_load);
  modport slave  (output rx_data, rx_valid,
                  input rx_ready, ram_address, ram_data, ram_load);
endinterface

// File: rtl/ram_loader_byte_assembler.sv
// byte_assembler: packs accepted bytes little-endian into a word.
//   clr       - restart at byte 0 (new load)
//   byte_en   - a byte is accepted this cycle
//   byte_in   - the byte
//   word      - registered word under assembly; stable once full until
//               the next byte is accepted
//   word_full - combinational: the byte accepted this cycle completes the word
module byte_assembler
  import ram_loader_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  byte_en,
  input  logic [7:0]            byte_in,
  output logic [DATA_WIDTH-1:0] word,
  output logic                  word_full
);
  localparam int BYTES_PER_WORD = bytes_per_word(DATA_WIDTH);
  localparam int IDX_W = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(BYTES_PER_WORD - 1);

  logic [IDX_W-1:0] idx;

  assign word_full = byte_en && (idx == LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      idx  <= '0;
      word <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (byte_en) begin
      word[idx*8 +: 8] <= byte_in;
      idx              <= word_full ? '0 : idx + 1'b1;
    end
  end
endmodule

// File: rtl/ram_loader.sv
// ram_loader: boot-time loader feeding a byte stream into the program RAM.
//   clk, rst            - clock, synchronous active-high reset
//   start               - begin a load (only honoured when idle)
//   base_addr           - first word address, sampled on accepted start
//   word_count          - words to load (0..2^ADDR_WIDTH), sampled on start
//   bus (master)        - byte stream in, RAM write port out
//   busy / done / error - load active / completion pulse / checksum error
// Each word: collect bytes, then SETUP (addr/data valid), STROBE
// (ram_load=1), HOLD (addr/data held), so the RAM sees a clean strobe with
// one cycle of setup and hold.
// Optional: RAM_LOADER_CHECKSUM_EN adds a trailer byte that must make the
// 8-bit sum of all data bytes zero; otherwise error is set (sticky until
// the next accepted start).
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   word_count,
  ram_loader_if.master          bus,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);
  state_t                  state, state_n;
  logic [ADDR_WIDTH:0]     remaining;
  logic [DATA_WIDTH-1:0]   word;
  logic                    word_full;
  logic                    start_acc;
  logic                    byte_acc;

  assign start_acc = start && (state == IDLE);
  assign byte_acc  = (state == COLLECT) && bus.rx_valid && bus.rx_ready;

  byte_assembler #(.DATA_WIDTH(DATA_WIDTH)) u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr      (start_acc),
    .byte_en  (byte_acc),
    .byte_in  (bus.rx_data),
    .word     (word),
    .word_full(word_full)
  );

  // The assembler's word register is the RAM data; no byte is accepted
  // between SETUP and HOLD so it is held across the strobe.
  assign bus.ram_data = word;

`ifdef RAM_LOADER_CHECKSUM_EN
  logic [7:0] sum;
  logic       chk_acc;

  assign chk_acc = (state == CHECK) && bus.rx_valid && bus.rx_ready;

  always_ff @(posedge clk) begin
    if (rst || start_acc) begin
      sum   <= '0;
      error <= 1'b0;
    end else begin
      if (byte_acc) sum <= sum + bus.rx_data;
      if (chk_acc)  error <= (8'(sum + bus.rx_data) != 8'd0);
    end
  end
`else
  assign error = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = (word_count == '0) ? DONE : COLLECT;
      COLLECT: if (word_full) state_n = SETUP;
      SETUP:   state_n = STROBE;
      STROBE:  state_n = HOLD;
      HOLD: begin
        // remaining is decremented on this same edge; 1 means last word
        if (remaining == (ADDR_WIDTH+1)'(1)) begin
`ifdef RAM_LOADER_CHECKSUM_EN
          state_n = CHECK;
`else
          state_n = DONE;
`endif
        end else begin
          state_n = COLLECT;
        end
      end
`ifdef RAM_LOADER_CHECKSUM_EN
      CHECK:   if (chk_acc) state_n = DONE;
`endif
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // Outputs are flops decoded from the next state, so each is a clean
  // register output (no decode glitch on ram_load).
  always_ff @(posedge clk) begin
    if (rst) begin
      busy            <= 1'b0;
      done            <= 1'b0;
      bus.rx_ready    <= 1'b0;
      bus.ram_load    <= 1'b0;
      bus.ram_address <= '0;
      remaining       <= '0;
    end else begin
      busy         <= (state_n != IDLE);
      done         <= (state_n == DONE);
      bus.rx_ready <= (state_n == COLLECT) || (state_n == CHECK);
      bus.ram_load <= (state_n == STROBE);
      if (start_acc) begin
        bus.ram_address <= base_addr;
        remaining       <= word_count;
      end else if (state == HOLD) begin
        bus.ram_address <= bus.ram_address + 1'b1;
        remaining       <= remaining - 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_ram_loader.sv
// tb_ram_loader: randomized bench for ram_loader. A RAM model captures
// writes on ram_load rising edges; expected writes are computed from the
// byte list (little-endian words at base+i, wrapping).
module tb_ram_loader;
  localparam int AW  = 12;
  localparam int DW  = 32;
  localparam int BPW = DW / 8;
`ifdef RAM_LOADER_CHECKSUM_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   word_count;
  logic          busy, done, error;

  ram_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  ram_loader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .word_count(word_count),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 clk = ~clk;

  int            n_chk = 0;
  int            n_err = 0;
  int            n_done = 0;
  wr_t           writes[$];
  logic [DW-1:0] ram [0:(1<<AW)-1];
  logic [7:0]    src[$];

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // RAM model + strobe timing monitor, sampled mid-cycle
  logic          pl = 1'b0;
  logic [AW-1:0] pa;
  logic [DW-1:0] pd;
  always @(negedge clk) begin
    if (bus.ram_load === 1'b1) begin
      chk("strobe_width", pl, 1'b0);
      if (pl !== 1'b1) begin
        chk("setup_addr", bus.ram_address, pa);
        chk("setup_data", bus.ram_data, pd);
        writes.push_back('{a: bus.ram_address, d: bus.ram_data});
        ram[bus.ram_address] = bus.ram_data;
      end
    end else if (pl === 1'b1) begin
      chk("hold_addr", bus.ram_address, pa);
      chk("hold_data", bus.ram_data, pd);
    end
    if (done === 1'b1) n_done++;
    pl = bus.ram_load;
    pa = bus.ram_address;
    pd = bus.ram_data;
  end

  task automatic poke_start(input int noise);
    start = busy && ($urandom_range(99) < noise);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap, input int noise);
    int t = 0;
    bit acc;
    while ($urandom_range(99) < gap) begin
      bus.rx_valid = 1'b0;
      bus.rx_data  = 8'($urandom);
      poke_start(noise);
      @(negedge clk);
    end
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    do begin
      poke_start(noise);
      acc = bus.rx_ready;
      @(negedge clk);
      t++;
    end while (!acc && t < 50);
    chk("rx_accept", acc, 1'b1);
    start = 1'b0;
    bus.rx_valid = 1'b0;
  endtask

  function automatic logic [7:0] good_trailer();
    logic [7:0] s = 8'd0;
    foreach (src[i]) s += src[i];
    return 8'(8'd0 - s);
  endfunction

  task automatic fill_src(input int n);
    src.delete();
    for (int i = 0; i < n; i++) src.push_back(8'($urandom));
  endtask

  // Runs one load of cnt words from src and checks it against the model.
  task automatic run_load(input logic [AW-1:0] base, input int cnt, input int gap,
                          input int noise, input logic [7:0] trailer);
    wr_t           exp_q[$];
    logic [7:0]    s = 8'd0;
    logic [DW-1:0] w;
    bit            exp_err;
    int            t = 0;
    for (int i = 0; i < cnt; i++) begin
      w = '0;
      for (int k = 0; k < BPW; k++) begin
        w[8*k +: 8] = src[i*BPW + k];
        s += src[i*BPW + k];
      end
      exp_q.push_back('{a: base + AW'(i), d: w});
    end
    exp_err = CHK_EN && (cnt > 0) && (8'(s + trailer) != 8'd0);
    writes.delete();
    n_done = 0;
    base_addr  = base;
    word_count = (AW+1)'(cnt);
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = AW'($urandom);
    word_count = (AW+1)'($urandom);
    chk("busy_on_start", busy, 1'b1);
    chk("error_clr_on_start", error, 1'b0);
    for (int i = 0; i < cnt*BPW; i++) send_byte(src[i], gap, noise);
    if (CHK_EN && cnt > 0) send_byte(trailer, gap, 0);
    while (done !== 1'b1 && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("done_seen", done, 1'b1);
    chk("error", error, exp_err);
    @(negedge clk);
    chk("done_width", done, 1'b0);
    chk("busy_after_done", busy, 1'b0);
    chk("done_count", n_done, 1);
    chk("write_count", writes.size(), cnt);
    for (int i = 0; i < cnt && i < writes.size(); i++) begin
      chk("wr_addr", writes[i].a, exp_q[i].a);
      chk("wr_data", writes[i].d, exp_q[i].d);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    // reset state, then idle with a byte offered
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_error", error, 1'b0);
    chk("rst_rx_ready", bus.rx_ready, 1'b0);
    chk("rst_ram_load", bus.ram_load, 1'b0);
    chk("rst_ram_address", bus.ram_address, '0);
    chk("rst_ram_data", bus.ram_data, '0);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h5A;
    repeat (5) @(negedge clk);
    chk("idle_rx_ready", bus.rx_ready, 1'b0);
    chk("idle_writes", writes.size(), 0);
    bus.rx_valid = 1'b0;

    // directed two-word load
    src = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
    run_load(12'h010, 2, 0, 0, good_trailer());
    chk("ram_010", ram[12'h010], 32'h44332211);
    chk("ram_011", ram[12'h011], 32'hDDCCBBAA);

    // address wrap
    fill_src(8);
    run_load(12'hFFF, 2, 20, 0, good_trailer());
    chk("wrap_lo_written", writes.size() > 1 ? writes[1].a : 12'hABC, 12'h000);

    // zero-length load
    run_load(12'h123, 0, 0, 0, 8'h00);

    // reset after two bytes of the first word
    fill_src(8);
    writes.delete();
    base_addr = 12'h200; word_count = 13'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_byte(src[0], 0, 0);
    send_byte(src[1], 0, 0);
    rst = 1'b1; bus.rx_valid = 1'b1; bus.rx_data = src[2];
    @(negedge clk);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_rx_ready", bus.rx_ready, 1'b0);
    chk("midrst_ram_load", bus.ram_load, 1'b0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    chk("midrst_idle_busy", busy, 1'b0);
    chk("midrst_writes", writes.size(), 0);
    bus.rx_valid = 1'b0;

    // random loads with gaps and start pulses while busy
    for (int r = 0; r < 6; r++) begin
      int c = $urandom_range(6, 1);
      fill_src(c * BPW);
      run_load(AW'($urandom), c, 40, 30, good_trailer());
    end

    // checksum trailer: good, bad (sticky), then cleared by next start
    src = '{8'h01, 8'h02, 8'h03, 8'h04};
    run_load(12'h020, 1, 0, 0, 8'hF6);
    run_load(12'h021, 1, 0, 0, 8'h00);
    repeat (5) @(negedge clk);
    chk("error_sticky", error, CHK_EN);
    run_load(12'h022, 1, 10, 0, 8'hF6);

    // full RAM in one load
    fill_src((1 << AW) * BPW);
    run_load(12'h800, 1 << AW, 0, 0, good_trailer());

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
